lsu_wb_ctrl: RTL and testbench

LSU_WB_CTRL -- requirements
Module: lsu_wb_ctrl

---
 rtl/lsu_wb_ctrl.sv | 83 ++++++++
 tb/tb_lsu_wb_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/lsu_wb_ctrl.sv
// lsu_wb_ctrl: load/store unit Wishbone classic master; LSU_TIMEOUT_EN enables the bus timeout abort
module lsu_wb_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdat_i,
  input  logic [3:0]  sel_i,
  input  logic        mis_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdat_o,
  output logic        fault_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, DRAIN} state_t;
  state_t state, state_d;
  logic we, fault, go, busy, to, fin;
  logic [31:0] adr, dat, rdat;
  logic [3:0] sel;
  assign go = state == IDLE && req_valid_i && !mis_i && !flush_i;
  assign busy = state == ACCESS || state == DRAIN;
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_i)
    cnt <= (rst_i || !busy) ? '0 : cnt + 1'b1;
  assign to = busy && cnt == TMAX;
`else
  assign to = 1'b0;
`endif
  assign fin = wb_ack_i || wb_err_i || to;
  always_comb begin
    state_d = state;
    state_d = state == IDLE   ? (go ? ACCESS : IDLE) :
              state == ACCESS ? (fin ? RESP : flush_i ? DRAIN : ACCESS) :
              state == DRAIN  ? (fin ? IDLE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      adr   <= '0;
      dat   <= '0;
      sel   <= '0;
      we    <= 1'b0;
      rdat  <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_d;
      fault <= state == ACCESS && (wb_err_i || (to && !wb_ack_i));
      if (go) begin
        adr <= {addr_i[31:2], 2'b00};
        dat <= wdat_i;
        sel <= sel_i;
        we  <= req_we_i;
      end
      if (state == ACCESS && wb_ack_i) rdat <= wb_dat_i;
    end
  end
  assign stall_o  = !rst_i && (go || busy);
  assign done_o   = state == RESP;
  assign fault_o  = fault;
  assign rdat_o   = rdat;
  assign wb_cyc_o = busy;
  assign wb_stb_o = busy;
  assign wb_we_o  = busy && we;
  assign wb_adr_o = adr;
  assign wb_dat_o = dat;
  assign wb_sel_o = sel;
endmodule

// File: tb/tb_lsu_wb_ctrl.sv
// tb_lsu_wb_ctrl: scoreboard bench for lsu_wb_ctrl, completions matched against queued expectations
module tb_lsu_wb_ctrl;
  logic clk = 1'b0, rst, req_valid, req_we, mis, flush, ack, err;
  logic [31:0] addr, wdat, rd;
  logic [3:0] sel;
  logic stall_o, done_o, fault_o, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] rdat_o, wb_adr_o, wb_dat_o;
  logic [3:0] wb_sel_o;
  int checks = 0, errors = 0, cyc_n = 0;
  typedef struct {logic [31:0] rdat; logic fault; logic chk_rdat; int cyc;} exp_t;
  exp_t sb[$];
  exp_t e;

  lsu_wb_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_we_i(req_we),
    .addr_i(addr), .wdat_i(wdat), .sel_i(sel), .mis_i(mis), .flush_i(flush),
    .stall_o(stall_o), .done_o(done_o), .rdat_o(rdat_o), .fault_o(fault_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(rd), .wb_ack_i(ack), .wb_err_i(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (done_o || fault_o) begin
      if (sb.size() == 0) chk("unexpected_done_fault", {30'd0, done_o, fault_o}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("done", done_o, 1'b1);
        chk("done_cycle", cyc_n, e.cyc);
        chk("fault", fault_o, e.fault);
        if (e.chk_rdat) chk("rdat", rdat_o, e.rdat);
      end
    end
  end

  task automatic idle_in();
    req_valid = 0; mis = 0; flush = 0; ack = 0; err = 0;
  endtask

  // resp: 0 ack, 1 err, 2 none (timeout), 3 err with ack; fl raises flush with the response
  task automatic access(input logic we_, input logic [31:0] a, d, input logic [3:0] s,
                        input int waits, input int resp, input logic fl, input logic [31:0] r);
    @(negedge clk);
    req_valid = 1; req_we = we_; addr = a; wdat = d; sel = s;
    #1;
    chk("stall_accept", stall_o, 1'b1);
    chk("cyc_accept", wb_cyc_o, 1'b0);
    sb.push_back('{rdat: r, fault: resp != 0, chk_rdat: !we_ && resp == 0, cyc: cyc_n + waits + 2});
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      req_valid = 0; ack = 0; err = 0;
      #1;
      chk("cyc", wb_cyc_o, 1'b1);
      chk("stb", wb_stb_o, 1'b1);
      chk("we", wb_we_o, we_);
      chk("adr", wb_adr_o, {a[31:2], 2'b00});
      chk("dat", wb_dat_o, d);
      chk("sel", wb_sel_o, s);
      chk("stall_busy", stall_o, 1'b1);
      if (i == waits) begin
        ack = resp == 0 || resp == 3;
        err = resp == 1 || resp == 3;
        rd = r;
        flush = fl;
      end
    end
    @(negedge clk);
    ack = 0; err = 0; flush = 0;
    #1;
    chk("cyc_after", wb_cyc_o, 1'b0);
    chk("stall_resp", stall_o, 1'b0);
  endtask

  initial begin
    idle_in();
    rst = 1; req_we = 0; addr = 0; wdat = 0; sel = 0; rd = 32'hFFFF_FFFF;
    ack = 1; req_valid = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_we", wb_we_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_fault", fault_o, 1'b0);
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_rdat", rdat_o, 32'd0);
    chk("rst_sel", wb_sel_o, 4'd0);
    rst = 0;
    idle_in();
    access(0, 32'h100, 32'h0, 4'hF, 0, 0, 0, 32'hDEADBEEF);
    access(1, 32'h203, 32'h5500_0000, 4'b1000, 3, 0, 0, 32'h1234_5678);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req_valid = 1; mis = k == 0; flush = k == 1; addr = 32'h300;
      repeat (3) begin
        #1;
        chk(k == 0 ? "mis_cyc" : "idle_flush_cyc", wb_cyc_o, 1'b0);
        chk(k == 0 ? "mis_stall" : "idle_flush_stall", stall_o, 1'b0);
        @(negedge clk);
      end
      idle_in();
    end
    access(0, 32'h404, 32'h0, 4'hF, 1, 1, 0, 32'hBAD0_BAD0);
    access(0, 32'h408, 32'h0, 4'hF, 0, 3, 0, 32'hBAD1_BAD1);
    access(0, 32'h40C, 32'h0, 4'hF, 2, 0, 1, 32'hCAFE_F00D);
    @(negedge clk);
    req_valid = 1; req_we = 0; addr = 32'h500;
    @(negedge clk);
    req_valid = 0; flush = 1;
    #1 chk("flush_cyc", wb_cyc_o, 1'b1);
    @(negedge clk);
    flush = 0;
    #1 chk("drain_cyc", wb_cyc_o, 1'b1);
    chk("drain_stall", stall_o, 1'b1);
    @(negedge clk);
    #1 chk("drain_cyc2", wb_cyc_o, 1'b1);
    ack = 1;
    @(negedge clk);
    ack = 0;
    #1 chk("drain_end_cyc", wb_cyc_o, 1'b0);
    chk("drain_end_stall", stall_o, 1'b0);
    @(negedge clk);
    req_valid = 1; addr = 32'h600;
    @(negedge clk);
    req_valid = 0;
    #1 chk("pre_rst_cyc", wb_cyc_o, 1'b1);
    rst = 1;
    @(negedge clk);
    #1 chk("mid_rst_cyc", wb_cyc_o, 1'b0);
    rst = 0; ack = 1;
    @(negedge clk);
    #1 chk("late_ack_cyc", wb_cyc_o, 1'b0);
    chk("late_ack_stall", stall_o, 1'b0);
    ack = 0;
`ifdef LSU_TIMEOUT_EN
    access(0, 32'h700, 32'h0, 4'hF, 3, 2, 0, 32'h0);
`endif
    for (int k = 0; k < 10; k++)
      access(1'($urandom_range(1)), $urandom, $urandom, 4'($urandom_range(15)),
             $urandom_range(3), $urandom_range(3) == 0 ? 1 : 0, 0, $urandom);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
